// File: rtl/mtm_alu_frame_pkg.sv
// Shared types and helpers for the mtm_Alu serial frame generator.
// Holds the error-injection mode enum, the opcode constants, the packet length and the CRC4 helper.
// Imported by mtm_alu_pkt_ser and mtm_alu_frame_gen.
package mtm_alu_frame_pkg;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CRC  = 2'd1,
      ERR_DATA = 2'd2,
      ERR_OP   = 2'd3
   } err_mode_t;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;
   localparam logic [2:0] BAD_OP = 3'b010;

   // start + flag + 8 payload + stop
   localparam int PKT_BITS = 11;

   // Widest CRC message: two 8-byte operands, the '1' marker and the opcode.
   localparam int CRC_MAX_BITS = 132;

   // CRC4, poly x^4+x+1, init 0, fed serially MSB first.
   // The message sits right-aligned in data; only the low nbits are used.
   function automatic logic [3:0] crc4(input logic [CRC_MAX_BITS-1:0] data, input int nbits);
      logic [3:0] crc;
      logic       fb;
      crc = 4'h0;
      fb  = 1'b0;
      for (int i = CRC_MAX_BITS - 1; i >= 0; i--) begin
         if (i < nbits) begin
            fb  = data[i] ^ crc[3];
            crc = {crc[2:0], 1'b0} ^ {2'b00, fb, fb};
         end
      end
      return crc;
   endfunction

endpackage

// File: rtl/mtm_alu_pkt_ser.sv
// Purpose: shifts one 11-bit packet {0, flag, payload, 1} onto sin MSB first, then GAP_BITS idle '1's.
// Latency: load in cycle L puts the start bit on sin in L+1; pkt_done is high while the last bit is on sin.
// Backpressure: none; a load in the pkt_done cycle chains the next packet with no idle bit in between.
// Ports: clk, rst (sync, active high), load/flag/pay (packet request), sin (registered serial line),
//        pkt_done (last bit of packet+gap on sin), stop_bit (stop bit on sin).
module mtm_alu_pkt_ser
   import mtm_alu_frame_pkg::*;
#(
   parameter int GAP_BITS = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       flag,
   input  logic [7:0] pay,
   output logic       sin,
   output logic       pkt_done,
   output logic       stop_bit
);

   localparam int              TOTAL    = PKT_BITS + GAP_BITS;
   localparam int              CW       = 5;
   localparam logic [CW-1:0]   LAST     = CW'(TOTAL - 1);
   localparam logic [CW-1:0]   STOP_IDX = CW'(PKT_BITS - 1);

   logic          active;
   logic [CW-1:0] cnt;     // index of the bit currently on sin
   logic [9:0]    sh;      // bits still to send after the current one

   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
         sh     <= '1;
         sin    <= 1'b1;
      end else if (load) begin
         active <= 1'b1;
         cnt    <= '0;
         sin    <= 1'b0;
         sh     <= {flag, pay, 1'b1};
      end else if (active) begin
         // Shifting in ones makes the gap bits and the post-packet idle come for free.
         sin <= sh[9];
         sh  <= {sh[8:0], 1'b1};
         if (cnt == LAST) begin
            active <= 1'b0;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         sin <= 1'b1;
      end
   end

   assign pkt_done = active && (cnt == LAST);
   assign stop_bit = active && (cnt == STOP_IDX);

endmodule

// File: rtl/mtm_alu_frame_gen.sv
// Purpose: builds one mtm_Alu input frame (B bytes, A bytes, CTL) and shifts it out on sin with error injection.
// Latency: start in cycle N -> LOAD in N+1 -> first start bit on sin in N+2; done one cycle after the last bit.
// Backpressure: start is accepted only while busy==0; requests during a frame are dropped, never queued.
// Ports: clk, rst (sync, active high), start, a_in/b_in/op_in/err_mode/rand_sel (sampled in LOAD only),
//        sin (serial line, idles 1), busy, done (1-cycle pulse), a_used/b_used (operands actually sent).
// Build option: define MTM_ALU_FRAME_GEN_LFSR_EN to add the corner-biased operand LFSR selected by rand_sel.
module mtm_alu_frame_gen
   import mtm_alu_frame_pkg::*;
#(
   parameter int          DATA_BYTES = 4,
   parameter int          GAP_BITS   = 0,
   parameter logic [31:0] LFSR_SEED  = 32'hACE1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [8*DATA_BYTES-1:0] a_in,
   input  logic [8*DATA_BYTES-1:0] b_in,
   input  logic [2:0]              op_in,
   input  logic [1:0]              err_mode,
   input  logic                    rand_sel,
   output logic                    sin,
   output logic                    busy,
   output logic                    done,
   output logic [8*DATA_BYTES-1:0] a_used,
   output logic [8*DATA_BYTES-1:0] b_used
);

   localparam int W      = 8 * DATA_BYTES;
   localparam int CNT_W  = 5;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]              state;
   logic [2*W-1:0]          ab_sh;     // remaining data bytes, next one in the top byte
   logic [7:0]              ctl_byte;
   logic [CNT_W-1:0]        pkt_cnt;   // packets handed to the serializer so far
   logic [CNT_W-1:0]        n_data;    // data packets in this frame

   logic [W-1:0]            a_sel;
   logic [W-1:0]            b_sel;
   err_mode_t               mode_in;
   logic [2:0]              op_eff;
   logic [CRC_MAX_BITS-1:0] crc_data;
   logic [3:0]              crc;

   logic                    ser_load;
   logic                    ser_flag;
   logic [7:0]              ser_pay;
   logic                    pkt_done;
   logic                    stop_bit;

   // ---------------------------------------------------------------- operand source
`ifdef MTM_ALU_FRAME_GEN_LFSR_EN
   logic [31:0] lfsr;

   // Galois form of x^32+x^22+x^2+x+1, shifting right.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   // Biased towards 00/FF so the ALU sees carry and overflow corners often.
   function automatic logic [7:0] corner_byte(input logic [31:0] s);
      case (s[1:0])
         2'b00:   return 8'h00;
         2'b11:   return 8'hFF;
         default: return s[15:8];
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_step(lfsr);
   end

   // Each byte looks 8 steps further down the sequence so adjacent bytes differ.
   always_comb begin
      logic [31:0] s;
      s     = lfsr;
      a_sel = a_in;
      b_sel = b_in;
      if (rand_sel) begin
         for (int k = 0; k < DATA_BYTES; k++) begin
            b_sel[8*k +: 8] = corner_byte(s);
            for (int j = 0; j < 8; j++) s = lfsr_step(s);
         end
         for (int k = 0; k < DATA_BYTES; k++) begin
            a_sel[8*k +: 8] = corner_byte(s);
            for (int j = 0; j < 8; j++) s = lfsr_step(s);
         end
      end
   end
`else
   assign a_sel = a_in;
   assign b_sel = b_in;

   logic unused_cfg;
   assign unused_cfg = rand_sel ^ (^LFSR_SEED);
`endif

   // ---------------------------------------------------------------- CTL field
   assign mode_in = err_mode_t'(err_mode);
   assign op_eff  = (mode_in == ERR_OP) ? BAD_OP : op_in;

   always_comb begin
      crc_data              = '0;
      crc_data[2*W+3:0]     = {b_sel, a_sel, 1'b1, op_eff};
      crc                   = crc4(crc_data, 2*W + 4);
   end

   // ---------------------------------------------------------------- packet issue
   always_comb begin
      ser_load = 1'b0;
      ser_flag = 1'b0;
      ser_pay  = ab_sh[2*W-1 -: 8];
      if (state == S_LOAD) begin
         // Operand registers are not written yet, so the first B byte comes straight from the source.
         ser_load = 1'b1;
         ser_pay  = b_sel[W-1 -: 8];
      end else if (((state == S_SEND) || (state == S_GAP)) && pkt_done) begin
         if (pkt_cnt < n_data) begin
            ser_load = 1'b1;
         end else if (pkt_cnt == n_data) begin
            ser_load = 1'b1;
            ser_flag = 1'b1;
            ser_pay  = ctl_byte;
         end
      end
   end

   // ---------------------------------------------------------------- frame FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         ab_sh    <= '0;
         ctl_byte <= '0;
         pkt_cnt  <= '0;
         n_data   <= '0;
         a_used   <= '0;
         b_used   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) state <= S_LOAD;
            end
            S_LOAD: begin
               a_used   <= a_sel;
               b_used   <= b_sel;
               ab_sh    <= {b_sel, a_sel} << 8;
               ctl_byte <= {1'b0, op_eff, (mode_in == ERR_CRC) ? ~crc : crc};
               n_data   <= CNT_W'(2 * DATA_BYTES) - {{(CNT_W-1){1'b0}}, (mode_in == ERR_DATA)};
               pkt_cnt  <= CNT_W'(1);
               state    <= S_SEND;
            end
            S_SEND, S_GAP: begin
               if (pkt_done) begin
                  if (pkt_cnt <= n_data) begin
                     pkt_cnt <= pkt_cnt + 1'b1;
                     state   <= S_SEND;
                     if (pkt_cnt < n_data) ab_sh <= ab_sh << 8;
                  end else begin
                     state <= S_DONE;
                  end
               end else if (stop_bit && (GAP_BITS > 0)) begin
                  state <= S_GAP;
               end
            end
            S_DONE: begin
               pkt_cnt <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

   mtm_alu_pkt_ser #(
      .GAP_BITS (GAP_BITS)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .flag     (ser_flag),
      .pay      (ser_pay),
      .sin      (sin),
      .pkt_done (pkt_done),
      .stop_bit (stop_bit)
   );

endmodule
